input_segment_buffer: RTL
=========================

INPUT_SEGMENT_BUFFER -- requirements
Module: input_segment_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bits per sample word.
REQ-002 SHALL have parameter DEPTH, default 8, words per frame (legal range 2..64).
REQ-003 SHALL have parameter CNT_WIDTH, default 6, fill-counter width (must satisfy 2**CNT_WIDTH >= DEPTH).
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port hold  in  1  freezes the input side (shift stages, counter, serial tap).
REQ-007 SHALL have port flush  in  1  synchronous discard of the partial frame.
REQ-008 SHALL have port in_valid  in  1  input word present.
REQ-009 SHALL have port in_data  in  DATA_WIDTH  input sample.
REQ-010 SHALL have port in_ready  out  1  input word will be accepted this cycle.
REQ-011 SHALL have port out_valid  out  1  complete frame is presented.
REQ-012 SHALL have port out_ready  in  1  consumer takes the frame.
REQ-013 SHALL have port out_data  out  DEPTH*DATA_WIDTH  frame; word i at bits [i*DATA_WIDTH +: DATA_WIDTH], word 0 = oldest.
REQ-014 SHALL have port serial_q  out  DATA_WIDTH  delay-line tap: the word accepted DEPTH acceptances earlier.
REQ-015 SHALL have port fill_count  out  CNT_WIDTH  words held in the partial frame (0..DEPTH-1).
REQ-016 SHALL have port drop_err  out  1  sticky: a word was offered while in_ready was low.

Function
REQ-017 Accept = in_valid & in_ready; in_ready SHALL be ~hold & ~flush & ~(fill_count==DEPTH-1 & out_valid & ~out_ready).
REQ-018 On accept, the DEPTH-stage shift chain SHALL shift by one (stage0 <= in_data); serial_q SHALL equal stage DEPTH-1.
REQ-019 On accept with fill_count < DEPTH-1, fill_count SHALL increment by 1.
REQ-020 On accept with fill_count == DEPTH-1, on the same edge: the output bank SHALL load {stages DEPTH-2..0, in_data} in oldest-first order, out_valid SHALL go to 1, and fill_count SHALL wrap to 0.
REQ-021 Frame latency: out_valid SHALL be high in the cycle immediately after the edge that accepted the DEPTH-th word.
REQ-022 Output handshake: out_valid & out_ready with no simultaneous capture SHALL clear out_valid at the edge; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 Simultaneous handshake and capture SHALL load the new frame and keep out_valid=1, with no bubble.
REQ-024 The output side SHALL operate independently of hold; hold=1 SHALL NOT alter out_valid or out_data.
REQ-025 flush=1 SHALL zero fill_count and all shift stages, SHALL leave a pending output frame intact, SHALL clear drop_err, and SHALL take priority over accept.
REQ-026 drop_err SHALL set when in_valid=1 and in_ready=0 with hold=0 and flush=0, and SHALL remain set until flush or reset.
REQ-027 Words offered while hold=1 SHALL NOT be accepted and SHALL NOT set drop_err.

Reset
REQ-028 rst=0 SHALL asynchronously clear all shift stages, the output bank, fill_count, out_valid and drop_err to 0; serial_q and out_data SHALL read 0.
REQ-029 Reset mid-frame SHALL discard the partial and pending frames; the first accept after release SHALL be word 0 of a new frame.

Structure
REQ-030 DATA_WIDTH and DEPTH defaults and the frame word-order convention SHALL live in the shared fft_pkg package.
REQ-031 Each shift stage SHALL be an instance of the sub-module dff_hold_async_low_reset (parameter DATA_WIDTH, enable = accept, synchronous clear = flush).
REQ-032 The counter, output bank and handshake logic SHALL be in the top level; there SHALL be no other sub-modules.

Verification
REQ-033 DEPTH=8: stream 1..8 with out_ready=1 -> out_valid=1 for one cycle after the 8th accept, word0=1 and word7=8, fill_count=0.
REQ-034 Stream 1..16 with out_ready=0 -> first frame held; in_ready=0 at fill_count=7; assert out_ready -> frame 9..16 follows with no bubble.
REQ-035 hold=1 for 3 cycles during a frame with in_valid=1 -> fill_count and serial_q frozen, drop_err=0, frame contents unaffected.
REQ-036 Flush at fill_count=5 with a pending frame -> fill_count=0, pending frame unchanged, next frame starts with the next accepted word.
REQ-037 Assert rst=0 asynchronously mid-frame (no clock edge) -> all outputs read 0 immediately; offer a word while blocked (in_ready=0) -> drop_err=1 until flush.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared frame geometry defaults and word-order helper
package fft_pkg;

  localparam int FFT_DATA_WIDTH = 32;
  localparam int FFT_DEPTH      = 8;

  // Frames are stored oldest-first: word idx sits at bit offset idx*width.
  function automatic int frame_word_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/dff_hold_async_low_reset.sv
// rtl/dff_hold_async_low_reset.sv - enabled register stage with sync clear and async low reset
module dff_hold_async_low_reset #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/input_segment_buffer.sv
// rtl/input_segment_buffer.sv - shift-chain segmenter that presents DEPTH-word frames
module input_segment_buffer
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DATA_WIDTH,
  parameter int DEPTH      = FFT_DEPTH,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hold,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DEPTH*DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0]       serial_q,
  output logic [CNT_WIDTH-1:0]        fill_count,
  output logic                        drop_err
);

  localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(DEPTH - 1);

  logic [CNT_WIDTH-1:0]        r_fill_count;
  logic                        r_out_valid;
  logic [DEPTH*DATA_WIDTH-1:0] r_out_bank;
  logic                        r_drop_err;

  logic [DATA_WIDTH-1:0]       w_stage [DEPTH];
  logic [DEPTH*DATA_WIDTH-1:0] w_next_frame;
  logic                        w_last;
  logic                        w_full_block;
  logic                        w_in_ready;
  logic                        w_accept;
  logic                        w_capture;
  logic                        w_drop;

  assign w_last       = (r_fill_count == LP_LAST);
  // The final word of a frame may only enter once the output bank can take it.
  assign w_full_block = w_last & r_out_valid & ~out_ready;
  assign w_in_ready   = ~hold & ~flush & ~w_full_block;
  assign w_accept     = in_valid & w_in_ready;
  assign w_capture    = w_accept & w_last;
  assign w_drop       = in_valid & ~w_in_ready & ~hold & ~flush;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      dff_hold_async_low_reset #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_accept),
        .i_clr (flush),
        .i_d   (in_data),
        .o_q   (w_stage[g])
      );
    end else begin : g_tail
      dff_hold_async_low_reset #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_accept),
        .i_clr (flush),
        .i_d   (w_stage[g-1]),
        .o_q   (w_stage[g])
      );
    end
  end

  // Stage DEPTH-2 holds the oldest word of the frame being completed.
  for (genvar g = 0; g < DEPTH - 1; g++) begin : g_frame
    assign w_next_frame[frame_word_lsb(g, DATA_WIDTH) +: DATA_WIDTH] = w_stage[DEPTH-2-g];
  end
  assign w_next_frame[frame_word_lsb(DEPTH - 1, DATA_WIDTH) +: DATA_WIDTH] = in_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fill_count <= '0;
    end else if (flush) begin
      r_fill_count <= '0;
    end else if (w_accept) begin
      r_fill_count <= w_last ? '0 : r_fill_count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_bank  <= '0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_bank  <= w_next_frame;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop_err <= 1'b0;
    end else if (flush) begin
      r_drop_err <= 1'b0;
    end else if (w_drop) begin
      r_drop_err <= 1'b1;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_bank;
  assign serial_q   = w_stage[DEPTH-1];
  assign fill_count = r_fill_count;
  assign drop_err   = r_drop_err;

endmodule
